sequence_detector_param: RTL and testbench
==========================================

# sequence_detector_param

Parametrised serial pattern detector, successor to the fixed 1011 Moore detector. It samples one bit per qualified clock into a WIDTH-bit history register. It compares the history against a runtime-loadable pattern and don't-care mask, and emits a registered one-cycle match pulse. Overlap and non-overlap modes are selected at runtime. It sits directly on a serial bit stream and feeds downstream framing/event logic.

## Interface
- WIDTH, 4: pattern length in bits, 2..32
- RESET_PATTERN, 4'b1011: pattern loaded at reset, WIDTH bits
- COUNT_WIDTH, 8: match counter width (used only with SEQ_DET_COUNT_EN)

Ports (the clock/reset names and the synchronous active-high reset are already decided):
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- sequence_in  in  1  serial data bit
- in_valid  in  1  qualifies sequence_in this cycle
- overlap_en  in  1  1 = overlapping matches allowed
- pattern_load  in  1  load pattern_in/mask_in this cycle
- pattern_in  in  WIDTH  new pattern; bit WIDTH-1 is the oldest (first-received) bit
- mask_in  in  WIDTH  1 = compare bit, 0 = don't care
- detector_out  out  1  registered match pulse
- match_count  out  COUNT_WIDTH  saturating match count (SEQ_DET_COUNT_EN only)
- count_clear  in  1  zero match_count (SEQ_DET_COUNT_EN only)

## Operation
- State:
  - history[WIDTH-1:0]
  - fill counter: $clog2(WIDTH+1) bits, saturates at WIDTH
  - pattern_q, mask_q
  - detector_out register
- Reset values: history 0, fill 0, pattern_q = RESET_PATTERN, mask_q all ones, detector_out 0, match_count 0.
- Valid bit (in_valid=1, pattern_load=0):
  - history_next = {history[WIDTH-2:0], sequence_in}
  - fill increments, saturating at WIDTH.
- Match: fill_next == WIDTH and ((history_next ^ pattern_q) & mask_q) == 0.
- On match:
  - detector_out_next = 1.
  - If overlap_en=0, fill_next forced to 0; history still shifts.
  - If overlap_en=1, fill stays at WIDTH.
- No valid bit: history and fill hold, detector_out_next = 0.
- pattern_load=1:
  - pattern_q and mask_q take the new values.
  - history and fill clear to 0; detector_out_next = 0.
  - Load wins over a simultaneous valid bit; that bit is discarded.
- mask_q all zero: every valid bit matches once fill reaches WIDTH (non-overlap: every WIDTH bits).
- overlap_en is sampled per valid bit; changing it mid-stream affects only the next match.

## Timing
- Latency: detector_out is high in the cycle after the rising edge that sampled the completing bit.
- The pulse lasts exactly one cycle per match. Back-to-back pulses are legal in overlap mode (e.g. pattern 1111 with a stream of ones).
- Reset asserted mid-stream: all state is cleared at that edge; partial history is lost, and no pulse is produced from pre-reset bits.
- match_count updates on the same edge as detector_out.

## Configuration
- SEQ_DET_COUNT_EN defined:
  - match_count and count_clear ports exist.
  - The counter increments on each match and saturates at 2^COUNT_WIDTH-1.
  - count_clear has priority over a simultaneous match (result 0).
- Undefined: both ports and the counter logic are absent; detector behaviour is otherwise identical.

## Structure
- Package sequence_detector_pkg:
  - WIDTH_MIN/WIDTH_MAX limits
  - default RESET_PATTERN constant
  - function fill_bits(WIDTH) returning the fill counter width
- Sub-module sat_counter (COUNT_WIDTH, inc, clear): the saturating match counter, instantiated only under SEQ_DET_COUNT_EN.

## Test plan
1. Overlap mode: reset, default pattern, overlap_en=1, in_valid=1, stream 1,0,1,1,0,1,1 -> detector_out pulses the cycle after bit 4 and the cycle after bit 7.
2. Non-overlap mode: same stream with overlap_en=0 -> single pulse after bit 4 only.
3. Qualifier gaps: stream 1,0,1,1 with in_valid=0 idle cycles (random garbage on sequence_in) between bits -> exactly one pulse, one cycle after the final valid bit.
4. Pattern load with mask: mid-stream pattern_load with pattern_in=4'b1111, mask_in=4'b1100 -> history cleared, no pulse. Then stream 1,1,0,0 -> pulse after bit 4.
5. Reset mid-stream: send 1,0,1, then reset for one cycle, then send 1 -> no pulse; detector_out=0 throughout.
6. Counter (SEQ_DET_COUNT_EN, COUNT_WIDTH=2):
   - 5 overlapping matches -> match_count = 3.
   - count_clear asserted on the same cycle as a match -> match_count = 0.

Source files
------------

// File: rtl/sequence_detector_pkg.sv
// Shared limits, reset defaults and helpers for the parametrised serial pattern detector.
package sequence_detector_pkg;

  localparam int unsigned WIDTH_MIN = 2;
  localparam int unsigned WIDTH_MAX = 32;

  localparam logic [3:0] DEFAULT_RESET_PATTERN = 4'b1011;

  typedef enum logic [1:0] {
    STEP_IDLE,
    STEP_SHIFT,
    STEP_LOAD
  } step_e;

  function automatic int unsigned fill_bits(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear; clear outranks a simultaneous increment.
module sat_counter #(
  parameter int unsigned COUNT_WIDTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   inc,
  input  logic                   clear,
  output logic [COUNT_WIDTH-1:0] count
);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/sequence_detector_param.sv
// Serial pattern detector with runtime pattern/mask and overlap control.
// Optional saturating match counter enabled by defining SEQ_DET_COUNT_EN.
module sequence_detector_param
  import sequence_detector_pkg::*;
#(
  parameter int unsigned       WIDTH         = 4,
  parameter logic [WIDTH-1:0]  RESET_PATTERN = WIDTH'(DEFAULT_RESET_PATTERN),
  parameter int unsigned       COUNT_WIDTH   = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sequence_in,
  input  logic             in_valid,
  input  logic             overlap_en,
  input  logic             pattern_load,
  input  logic [WIDTH-1:0] pattern_in,
  input  logic [WIDTH-1:0] mask_in,
  output logic             detector_out
`ifdef SEQ_DET_COUNT_EN
  ,
  input  logic                   count_clear,
  output logic [COUNT_WIDTH-1:0] match_count
`endif
);

  localparam int unsigned       FILL_W    = fill_bits(WIDTH);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(WIDTH);
  // Out-of-range parameter sets never report a match.
  localparam bit CFG_OK = (WIDTH >= WIDTH_MIN) && (WIDTH <= WIDTH_MAX) && (COUNT_WIDTH >= 1);

  logic [WIDTH-1:0]  history;
  logic [WIDTH-1:0]  history_next;
  logic [WIDTH-1:0]  pattern_q;
  logic [WIDTH-1:0]  mask_q;
  logic [FILL_W-1:0] fill;
  logic [FILL_W-1:0] fill_next;
  logic [FILL_W-1:0] fill_inc;
  logic              match;
  step_e             step;

  always_comb begin
    step = STEP_IDLE;
    if (pattern_load) begin
      step = STEP_LOAD;
    end else if (in_valid) begin
      step = STEP_SHIFT;
    end
  end

  always_comb begin
    history_next = history;
    fill_next    = fill;
    fill_inc     = fill;
    match        = 1'b0;
    unique case (step)
      STEP_SHIFT: begin
        history_next = {history[WIDTH-2:0], sequence_in};
        fill_inc     = (fill == FILL_FULL) ? fill : fill + 1'b1;
        match        = CFG_OK && (fill_inc == FILL_FULL) &&
                       (((history_next ^ pattern_q) & mask_q) == '0);
        // Non-overlap restarts the fill count but keeps shifting history.
        fill_next    = (match && !overlap_en) ? '0 : fill_inc;
      end
      STEP_LOAD: begin
        history_next = '0;
        fill_next    = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      history      <= '0;
      fill         <= '0;
      pattern_q    <= RESET_PATTERN;
      mask_q       <= '1;
      detector_out <= 1'b0;
    end else begin
      history      <= history_next;
      fill         <= fill_next;
      detector_out <= match;
      if (pattern_load) begin
        pattern_q <= pattern_in;
        mask_q    <= mask_in;
      end
    end
  end

`ifdef SEQ_DET_COUNT_EN
  sat_counter #(
    .COUNT_WIDTH(COUNT_WIDTH)
  ) u_match_counter (
    .clock(clock),
    .reset(reset),
    .inc  (match),
    .clear(count_clear),
    .count(match_count)
  );
`endif

endmodule

// File: tb/tb_sequence_detector_param.sv
// Self-checking bench for sequence_detector_param: directed scenarios plus random stream
// compared against a queue-based window model. Counter checks run when SEQ_DET_COUNT_EN is defined.
module tb_sequence_detector_param;

  localparam int unsigned WIDTH   = 4;
  localparam int unsigned CW      = 2;
  localparam int unsigned CNT_MAX = (1 << CW) - 1;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             sequence_in = 1'b0;
  logic             in_valid = 1'b0;
  logic             overlap_en = 1'b0;
  logic             pattern_load = 1'b0;
  logic [WIDTH-1:0] pattern_in = '0;
  logic [WIDTH-1:0] mask_in = '0;
  logic             detector_out;
  logic             count_clear = 1'b0;
`ifdef SEQ_DET_COUNT_EN
  logic [CW-1:0]    match_count;
`endif

  sequence_detector_param #(
    .WIDTH        (WIDTH),
    .RESET_PATTERN(4'b1011),
    .COUNT_WIDTH  (CW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .sequence_in (sequence_in),
    .in_valid    (in_valid),
    .overlap_en  (overlap_en),
    .pattern_load(pattern_load),
    .pattern_in  (pattern_in),
    .mask_in     (mask_in),
    .detector_out(detector_out)
`ifdef SEQ_DET_COUNT_EN
    ,
    .count_clear (count_clear),
    .match_count (match_count)
`endif
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int pulses = 0;

  // Reference model: received-bit window since the last restart.
  bit               q[$];
  logic [WIDTH-1:0] m_pat;
  logic [WIDTH-1:0] m_msk;
  logic             exp_out;
  int unsigned      exp_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit window_hits();
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (m_msk[i] && (q[WIDTH-1-i] != m_pat[i])) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    q.delete();
    m_pat   = 4'b1011;
    m_msk   = '1;
    exp_out = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic model_step(input logic v, input logic b, input logic ld,
                            input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] m,
                            input logic clr, input logic ovl);
    bit hit;
    hit = 1'b0;
    if (ld) begin
      m_pat = p;
      m_msk = m;
      q.delete();
    end else if (v) begin
      q.push_back(b);
      if (q.size() > WIDTH) void'(q.pop_front());
      if ((q.size() == WIDTH) && window_hits()) begin
        hit = 1'b1;
        if (!ovl) q.delete();
      end
    end
    exp_out = hit;
    if (clr) exp_cnt = 0;
    else if (hit && (exp_cnt < CNT_MAX)) exp_cnt++;
  endtask

  task automatic compare_outputs();
    check("detector_out", {31'd0, detector_out}, {31'd0, exp_out});
    if (detector_out === 1'b1) pulses++;
`ifdef SEQ_DET_COUNT_EN
    check("match_count", 32'(match_count), exp_cnt);
`endif
  endtask

  task automatic step(input logic v, input logic b, input logic ld,
                      input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] m, input logic clr);
    @(negedge clock);
    in_valid = v; sequence_in = b; pattern_load = ld;
    pattern_in = p; mask_in = m; count_clear = clr;
    @(posedge clock);
    model_step(v, b, ld, p, m, clr, overlap_en);
    #1;
    compare_outputs();
  endtask

  task automatic bitv(input logic b);
    step(1'b1, b, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 1'($urandom), 1'b0, '0, '0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    in_valid = 1'b1; sequence_in = 1'b1; pattern_load = 1'b0; count_clear = 1'b0;
    @(posedge clock);
    model_reset();
    #1;
    compare_outputs();
    @(negedge clock);
    reset = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    logic [6:0] stream;
    stream = 7'b1011011;
    model_reset();

    // 1: overlap, two pulses
    do_reset();
    overlap_en = 1'b1;
    pulses = 0;
    for (int i = 6; i >= 0; i--) bitv(stream[i]);
    check("t1_overlap_pulses", pulses, 2);

    // 2: non-overlap, single pulse
    do_reset();
    overlap_en = 1'b0;
    pulses = 0;
    for (int i = 6; i >= 0; i--) bitv(stream[i]);
    check("t2_nonoverlap_pulses", pulses, 1);

    // 3: qualifier gaps with garbage on sequence_in
    do_reset();
    pulses = 0;
    bitv(1'b1); idle(); idle();
    bitv(1'b0); idle();
    bitv(1'b1); idle(); idle(); idle();
    bitv(1'b1);
    check("t3_gap_pulse_now", {31'd0, detector_out}, 32'd1);
    idle(); idle();
    check("t3_gap_pulses", pulses, 1);

    // 4: mid-stream load with mask
    do_reset();
    pulses = 0;
    bitv(1'b1); bitv(1'b0); bitv(1'b1);
    step(1'b1, 1'b1, 1'b1, 4'b1111, 4'b1100, 1'b0);
    check("t4_load_no_pulse", pulses, 0);
    bitv(1'b1); bitv(1'b1); bitv(1'b0); bitv(1'b0);
    check("t4_masked_pulse", pulses, 1);

    // mask all zero, non-overlap: pulse every WIDTH bits
    overlap_en = 1'b0;
    step(1'b0, 1'b0, 1'b1, 4'b0101, 4'b0000, 1'b0);
    pulses = 0;
    for (int i = 0; i < 8; i++) bitv(1'($urandom));
    check("mask_zero_pulses", pulses, 2);

    // 5: reset mid-stream
    do_reset();
    pulses = 0;
    bitv(1'b1); bitv(1'b0); bitv(1'b1);
    do_reset();
    bitv(1'b1); idle();
    check("t5_reset_pulses", pulses, 0);

`ifdef SEQ_DET_COUNT_EN
    // 6: saturating counter and clear priority
    do_reset();
    overlap_en = 1'b1;
    step(1'b0, 1'b0, 1'b1, 4'b1111, 4'b1111, 1'b0);
    for (int i = 0; i < 8; i++) bitv(1'b1);
    check("t6_count_saturated", 32'(match_count), 32'd3);
    step(1'b1, 1'b1, 1'b0, '0, '0, 1'b1);
    check("t6_clear_pulse", {31'd0, detector_out}, 32'd1);
    check("t6_clear_wins", 32'(match_count), 32'd0);
`endif

    // random stream against the model
    do_reset();
    for (int n = 0; n < 600; n++) begin
      int unsigned r;
      r = $urandom_range(0, 99);
      if ((n % 23) == 0) overlap_en = 1'($urandom);
      if (r < 2) do_reset();
      else if (r < 5) step(1'($urandom), 1'($urandom), 1'b1, WIDTH'($urandom),
                           (r == 4) ? '0 : WIDTH'($urandom | 32'hC), 1'b0);
      else step(($urandom_range(0, 9) < 7), 1'($urandom), 1'b0, '0, '0,
                ($urandom_range(0, 29) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
